clint_timer: RTL and testbench

CLINT_TIMER -- requirements
Module: clint_timer

---
 rtl/clint_timer_pkg.sv | 43 ++++
 rtl/clint_timer_prescaler.sv | 49 ++++
 rtl/clint_timer.sv | 165 ++++++++++++++++
 tb/tb_clint_timer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_timer_pkg.sv
// -----------------------------------------------------------------------------
// clint_timer_pkg
//   Shared definitions for the CLINT machine timer: register byte offsets,
//   the decoded register-select enum, reset constants and the address
//   decode helper used by clint_timer.
//
//   Optional feature macro: TIMER_PRESCALE_EN (see clint_timer.sv).
// -----------------------------------------------------------------------------
package clint_timer_pkg;

  // Register byte offsets within the 32-byte timer window.
  localparam logic [4:0] TMR_MTIME_LO    = 5'h00;
  localparam logic [4:0] TMR_MTIME_HI    = 5'h04;
  localparam logic [4:0] TMR_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] TMR_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] TMR_PRESCALE    = 5'h10;

  // mtimecmp resets to all ones so the interrupt cannot fire before software
  // has programmed a compare value.
  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    SEL_MTIME_LO,
    SEL_MTIME_HI,
    SEL_MTIMECMP_LO,
    SEL_MTIMECMP_HI,
    SEL_PRESCALE,
    SEL_NONE
  } reg_sel_e;

  // Word-aligned decode: the byte-lane bits [1:0] never affect selection.
  function automatic reg_sel_e decode_addr(input logic [4:2] word_addr);
    case ({word_addr, 2'b00})
      TMR_MTIME_LO:    return SEL_MTIME_LO;
      TMR_MTIME_HI:    return SEL_MTIME_HI;
      TMR_MTIMECMP_LO: return SEL_MTIMECMP_LO;
      TMR_MTIMECMP_HI: return SEL_MTIMECMP_HI;
      TMR_PRESCALE:    return SEL_PRESCALE;
      default:         return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/clint_timer_prescaler.sv
// -----------------------------------------------------------------------------
// timer_prescaler
//   Divides the system clock into mtime ticks. An 8-bit counter runs from 0
//   up to prescale_i; the cycle on which it equals prescale_i is a tick and
//   the counter returns to 0, so a prescale of N gives one tick every N+1
//   cycles (N=0 ticks every cycle). clear_i restarts the count.
//
//   Only compiled when TIMER_PRESCALE_EN is defined; the default build has
//   no prescaler at all.
//
//   Ports:
//     clk         system clock
//     reset       asynchronous active-low reset
//     prescale_i  current prescale value (divide by prescale_i + 1)
//     clear_i     restart the count (software wrote the prescale register)
//     tick_o      one-cycle tick enable for mtime
// -----------------------------------------------------------------------------
`ifdef TIMER_PRESCALE_EN
module timer_prescaler (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] prescale_i,
  input  logic       clear_i,
  output logic       tick_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign tick_o = (cnt_q == prescale_i);

  always_comb begin
    if (clear_i || tick_o) begin
      cnt_d = 8'h00;
    end else begin
      cnt_d = cnt_q + 8'h01;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 8'h00;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/clint_timer.sv
// -----------------------------------------------------------------------------
// clint_timer
//   RISC-V CLINT-style machine timer: a free-running 64-bit mtime counter, a
//   64-bit mtimecmp register and a level-sensitive timer interrupt raised
//   while mtime >= mtimecmp. Registers are accessed as 32-bit halves over a
//   simple strobe bus with one-cycle registered read latency.
//
//   Register map (byte offsets, bits [1:0] ignored):
//     0x00 mtime[31:0]     0x04 mtime[63:32]
//     0x08 mtimecmp[31:0]  0x0C mtimecmp[63:32]
//     0x10 prescale[7:0]   (reads 0 unless TIMER_PRESCALE_EN)
//     0x14-0x1C unmapped: read 0, writes ignored
//
//   Optional feature macro: TIMER_PRESCALE_EN adds an 8-bit prescale register
//   and the timer_prescaler sub-module; without it mtime ticks every cycle.
//
//   Parameters:
//     TICK_RST         reset value of mtime[31:0]
//
//   Ports:
//     clk              system clock, all state changes on the rising edge
//     reset            asynchronous active-low reset
//     tmr_we           write strobe
//     tmr_re           read strobe
//     tmr_addr         byte offset
//     tmr_wdata        write data
//     tmr_rdata        registered read data, held while tmr_rvalid is low
//     tmr_rvalid       one-cycle read-data-valid pulse
//     timer_interrupt  machine timer interrupt request (MIP.MTIP source)
// -----------------------------------------------------------------------------
module clint_timer
  import clint_timer_pkg::*;
#(
  parameter logic [31:0] TICK_RST = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tmr_we,
  input  logic        tmr_re,
  input  logic [4:0]  tmr_addr,
  input  logic [31:0] tmr_wdata,
  output logic [31:0] tmr_rdata,
  output logic        tmr_rvalid,
  output logic        timer_interrupt
);

  reg_sel_e    sel;
  logic        tick;
  logic [31:0] prescale_rd;
  logic [31:0] rd_mux;

  logic [63:0] mtime_q,    mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [31:0] rdata_q;
  logic        rvalid_q;
  logic        irq_q;

  // Accesses are always full-word, so the byte-lane address bits carry no
  // information.
  logic unused_addr_bits;
  assign unused_addr_bits = ^tmr_addr[1:0];

  assign sel = decode_addr(tmr_addr[4:2]);

  // ---------------------------------------------------------------------------
  // Tick source
  // ---------------------------------------------------------------------------
`ifdef TIMER_PRESCALE_EN
  logic [7:0] prescale_q;
  logic       wr_prescale;

  assign wr_prescale = tmr_we && (sel == SEL_PRESCALE);
  assign prescale_rd = {24'h0, prescale_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescale_q <= 8'h00;
    end else if (wr_prescale) begin
      prescale_q <= tmr_wdata[7:0];
    end
  end

  timer_prescaler u_prescaler (
    .clk        (clk),
    .reset      (reset),
    .prescale_i (prescale_q),
    .clear_i    (wr_prescale),
    .tick_o     (tick)
  );
`else
  assign tick        = 1'b1;
  assign prescale_rd = 32'h0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default on entry;
  // a path that leaves it unassigned would infer a latch.
  always_comb begin
    mtime_d = mtime_q;
    if (tmr_we && (sel == SEL_MTIME_LO)) begin
      mtime_d = {mtime_q[63:32], tmr_wdata};
    end else if (tmr_we && (sel == SEL_MTIME_HI)) begin
      mtime_d = {tmr_wdata, mtime_q[31:0]};
    end else if (tick) begin
      // A single 64-bit add carries a low-word wrap into the high word in
      // the same cycle; a software write above drops the whole increment.
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_comb begin
    mtimecmp_d = mtimecmp_q;
    if (tmr_we && (sel == SEL_MTIMECMP_LO)) begin
      mtimecmp_d = {mtimecmp_q[63:32], tmr_wdata};
    end else if (tmr_we && (sel == SEL_MTIMECMP_HI)) begin
      mtimecmp_d = {tmr_wdata, mtimecmp_q[31:0]};
    end
  end

  // Read mux uses pre-edge register values, so a read that coincides with a
  // write to the same offset returns the old contents.
  always_comb begin
    rd_mux = 32'h0;
    case (sel)
      SEL_MTIME_LO:    rd_mux = mtime_q[31:0];
      SEL_MTIME_HI:    rd_mux = mtime_q[63:32];
      SEL_MTIMECMP_LO: rd_mux = mtimecmp_q[31:0];
      SEL_MTIMECMP_HI: rd_mux = mtimecmp_q[63:32];
      SEL_PRESCALE:    rd_mux = prescale_rd;
      default:         rd_mux = 32'h0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mtime_q    <= {32'h0, TICK_RST};
      mtimecmp_q <= MTIMECMP_RST;
      rdata_q    <= 32'h0;
      rvalid_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      rvalid_q   <= tmr_re;
      if (tmr_re) begin
        rdata_q <= rd_mux;
      end
      // Level-sensitive compare on pre-edge values: lags the condition by
      // one cycle and clears only when the condition itself goes false.
      irq_q <= (mtime_q >= mtimecmp_q);
    end
  end

  assign tmr_rdata       = rdata_q;
  assign tmr_rvalid      = rvalid_q;
  assign timer_interrupt = irq_q;

endmodule

// File: tb/tb_clint_timer.sv
// -----------------------------------------------------------------------------
// tb_clint_timer
//   Self-checking bench for clint_timer. A register-level model tracks what
//   mtime, mtimecmp, prescale and the bus outputs must be; a compare process
//   checks rdata, rvalid and timer_interrupt on every falling edge, and the
//   directed sequence adds hand-computed literal expectations.
//   Works with or without TIMER_PRESCALE_EN defined.
// -----------------------------------------------------------------------------
module tb_clint_timer;

  localparam logic [31:0] TICK_RST = 32'h0;
`ifdef TIMER_PRESCALE_EN
  localparam bit PRE_EN = 1'b1;
`else
  localparam bit PRE_EN = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        tmr_we = 1'b0;
  logic        tmr_re = 1'b0;
  logic [4:0]  tmr_addr = 5'h0;
  logic [31:0] tmr_wdata = 32'h0;
  logic [31:0] tmr_rdata;
  logic        tmr_rvalid;
  logic        timer_interrupt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  clint_timer #(.TICK_RST(TICK_RST)) dut (
    .clk             (clk),
    .reset           (reset),
    .tmr_we          (tmr_we),
    .tmr_re          (tmr_re),
    .tmr_addr        (tmr_addr),
    .tmr_wdata       (tmr_wdata),
    .tmr_rdata       (tmr_rdata),
    .tmr_rvalid      (tmr_rvalid),
    .timer_interrupt (timer_interrupt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: registers as plain 64-bit numbers
  // ---------------------------------------------------------------------------
  logic [63:0] m_time, m_cmp;
  logic [7:0]  m_pre, m_cnt;
  logic [31:0] m_rdata;
  logic        m_rvalid, m_irq;

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a[4:2])
      3'd0:    return m_time[31:0];
      3'd1:    return m_time[63:32];
      3'd2:    return m_cmp[31:0];
      3'd3:    return m_cmp[63:32];
      3'd4:    return PRE_EN ? {24'h0, m_pre} : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  // mtime advances on cycles where the divider phase reaches the prescale.
  function automatic bit model_tick();
    return PRE_EN ? (m_cnt == m_pre) : 1'b1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_time   <= {32'h0, TICK_RST};
      m_cmp    <= 64'hFFFF_FFFF_FFFF_FFFF;
      m_pre    <= 8'h0;
      m_cnt    <= 8'h0;
      m_rdata  <= 32'h0;
      m_rvalid <= 1'b0;
      m_irq    <= 1'b0;
    end else begin
      m_irq    <= (m_time >= m_cmp);
      m_rvalid <= tmr_re;
      if (tmr_re) m_rdata <= model_read(tmr_addr);
      if (tmr_we && tmr_addr[4:2] == 3'd0)      m_time <= {m_time[63:32], tmr_wdata};
      else if (tmr_we && tmr_addr[4:2] == 3'd1) m_time <= {tmr_wdata, m_time[31:0]};
      else if (model_tick())                    m_time <= m_time + 64'd1;
      if (tmr_we && tmr_addr[4:2] == 3'd2) m_cmp <= {m_cmp[63:32], tmr_wdata};
      if (tmr_we && tmr_addr[4:2] == 3'd3) m_cmp <= {tmr_wdata, m_cmp[31:0]};
      if (PRE_EN && tmr_we && tmr_addr[4:2] == 3'd4) begin
        m_pre <= tmr_wdata[7:0];
        m_cnt <= 8'h0;
      end else if (model_tick()) begin
        m_cnt <= 8'h0;
      end else begin
        m_cnt <= m_cnt + 8'h1;
      end
    end
  end

  // Cycle-by-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_rvalid", tmr_rvalid, m_rvalid);
      check("cyc_rdata", tmr_rdata, m_rdata);
      check("cyc_irq", timer_interrupt, m_irq);
    end
  end

  // ---------------------------------------------------------------------------
  // Bus tasks: called on a falling edge, return on the next falling edge
  // ---------------------------------------------------------------------------
  task automatic bus(input logic w, input logic r, input logic [4:0] a,
                     input logic [31:0] d, output logic [31:0] q);
    tmr_we = w; tmr_re = r; tmr_addr = a; tmr_wdata = d;
    @(negedge clk);
    q = tmr_rdata;
    tmr_we = 1'b0; tmr_re = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] q);
    bus(1'b0, 1'b1, a, 32'h0, q);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    logic [31:0] unused_q;
    bus(1'b1, 1'b0, a, d, unused_q);
  endtask

  logic [31:0] q, q2;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rdata", tmr_rdata, 32'h0);
    check("rst_rvalid", tmr_rvalid, 1'b0);
    check("rst_irq", timer_interrupt, 1'b0);
    chk_en = 1'b1;
    reset = 1'b1;

    // Idle 10 cycles, then read mtime low
    repeat (10) @(negedge clk);
    rd(5'h00, q);
    check("idle_mtime_lo", q, 32'd10 + TICK_RST);
    check("idle_irq", timer_interrupt, 1'b0);

    // Compare at 20: interrupt rises one cycle after mtime reaches 20
    wr(5'h08, 32'd20);
    wr(5'h0C, 32'd0);
    for (int i = 0; i < 40 && !timer_interrupt; i++) @(negedge clk);
    check("irq_rise", timer_interrupt, 1'b1);
    rd(5'h00, q);
    check("mtime_after_irq", q, 32'd21);
    wr(5'h0C, 32'd1);
    check("irq_hold_after_cmp_write", timer_interrupt, 1'b1);
    @(negedge clk);
    check("irq_fall", timer_interrupt, 1'b0);

    // Low-word carry into high word
    wr(5'h00, 32'hFFFF_FFFE);
    wr(5'h04, 32'h0);
    repeat (2) @(negedge clk);
    rd(5'h00, q);
    check("carry_lo", q, 32'h0);
    rd(5'h04, q);
    check("carry_hi", q, 32'h1);

    // Full 64-bit wrap
    wr(5'h00, 32'hFFFF_FFFF);
    wr(5'h04, 32'hFFFF_FFFF);
    rd(5'h00, q);
    check("allones_lo", q, 32'hFFFF_FFFF);
    rd(5'h00, q);
    check("wrap_lo", q, 32'h0);
    rd(5'h04, q);
    check("wrap_hi", q, 32'h0);

    // Software write beats the tick in the same cycle
    wr(5'h00, 32'd5);
    rd(5'h00, q);
    check("write_beats_tick", q, 32'd5);
    rd(5'h00, q);
    check("tick_after_write", q, 32'd6);

    // Simultaneous read and write of one offset returns the old value
    bus(1'b1, 1'b1, 5'h08, 32'd99, q);
    check("rw_same_old", q, 32'd20);
    rd(5'h0B, q);
    check("rw_same_new_bytelane", q, 32'd99);

    // Unmapped offsets
    bus(1'b1, 1'b1, 5'h14, 32'hDEAD_BEEF, q);
    check("unmapped_14", q, 32'h0);
    rd(5'h1C, q);
    check("unmapped_1c", q, 32'h0);

`ifdef TIMER_PRESCALE_EN
    wr(5'h10, 32'hABCD_EF03);
    rd(5'h10, q);
    check("prescale_read", q, 32'h3);
    rd(5'h00, q);
    repeat (3) @(negedge clk);
    rd(5'h00, q2);
    check("prescale_one_tick_per_4", q2 - q, 32'd1);
    wr(5'h10, 32'h0);
`else
    wr(5'h10, 32'h3);
    rd(5'h10, q);
    check("prescale_absent", q, 32'h0);
`endif

    // Reset during a pending read
    tmr_re = 1'b1;
    tmr_addr = 5'h00;
    #2 reset = 1'b0;
    @(negedge clk);
    tmr_re = 1'b0;
    check("midrst_rvalid", tmr_rvalid, 1'b0);
    check("midrst_rdata", tmr_rdata, 32'h0);
    check("midrst_irq", timer_interrupt, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_rvalid", tmr_rvalid, 1'b0);
    rd(5'h08, q);
    check("post_rst_cmp_lo", q, 32'hFFFF_FFFF);
    rd(5'h0C, q);
    check("post_rst_cmp_hi", q, 32'hFFFF_FFFF);
    rd(5'h10, q);
    check("post_rst_prescale", q, 32'h0);
    rd(5'h00, q);
    check("post_rst_mtime_lo", q, 32'd4 + TICK_RST);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
